// File: rtl/fmps_readout_sequencer_if.sv
// Bundle of readout-RAM, stream and status signals around fmps_readout_sequencer.
// master = sequencer side, slave = environment (RAM, CSR, stream sink) side.
interface fmps_readout_sequencer_if #(
  parameter int INDEX_WIDTH = 5
);
  logic                          readoutActive;
  logic                          readoutValid;
  logic                          FAstrobe;
  logic [(2**INDEX_WIDTH)-1:0]   fmpsBitmapAll;
  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress;
  logic [31:0]                   fmpsReadout;
  logic [31:0]                   m_tdata;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tready;
  logic                          busy;
  logic                          scanDone;
  logic                          errorStrobe;
  logic [2:0]                    errorCode;
  logic [15:0]                   errorCount;
  logic [7:0]                    cycleCounter;

  modport master (
    input  readoutActive, readoutValid, FAstrobe, fmpsBitmapAll, fmpsReadout, m_tready,
    output fmpsReadoutAddress, m_tdata, m_tvalid, m_tlast, busy, scanDone,
           errorStrobe, errorCode, errorCount, cycleCounter
  );

  modport slave (
    output readoutActive, readoutValid, FAstrobe, fmpsBitmapAll, fmpsReadout, m_tready,
    input  fmpsReadoutAddress, m_tdata, m_tvalid, m_tlast, busy, scanDone,
           errorStrobe, errorCode, errorCount, cycleCounter
  );
endinterface

// File: rtl/fmps_readout_sequencer.sv
// Walks the per-FMPS readout RAM on each acquisition event and streams present words out.
// Word field checks are built only when FMPS_READOUT_CHECK_EN is defined.
module fmps_readout_sequencer #(
  parameter int          INDEX_WIDTH = 5,
  parameter logic [15:0] DATA_MAGIC  = 16'hCACA
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  fmps_readout_sequencer_if.master bus
);
  localparam int                     N        = 2**INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] ADDR_ONE = INDEX_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] addr_q, addr_d;
  logic [N-1:0]           bmap_q, bmap_d;
  logic [N-1:0]           pend_bmap_q, pend_bmap_d;
  logic                   pending_q, pending_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   ra_q, rv_q;
  logic [7:0]             cc_q;
  logic                   trigger;
  logic                   present;
  logic                   last_here;

  assign trigger   = (bus.readoutValid & ~rv_q) | (~bus.readoutActive & ra_q);
  assign present   = bmap_q[addr_q];
  assign last_here = ((bmap_q >> addr_q) >> 1) == '0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bmap_d      = bmap_q;
    pend_bmap_d = pend_bmap_q;
    pending_d   = pending_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;

    // A trigger during a scan is remembered once, with its own bitmap snapshot.
    if (state_q != S_IDLE && trigger && !pending_q) begin
      pending_d   = 1'b1;
      pend_bmap_d = bus.fmpsBitmapAll;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          bmap_d  = bus.fmpsBitmapAll;
          addr_d  = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (present) begin
          tdata_d = bus.fmpsReadout;
          tlast_d = last_here;
          state_d = S_EMIT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_EMIT: begin
        if (bus.m_tready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == '1) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        addr_d = '0;
        if (pending_q) begin
          pending_d = 1'b0;
          bmap_d    = pend_bmap_q;
          state_d   = S_SETTLE;
        end else if (trigger) begin
          // Trigger landing in DONE starts the next scan directly rather than queueing.
          pending_d = 1'b0;
          bmap_d    = bus.fmpsBitmapAll;
          state_d   = S_SETTLE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bmap_q      <= '0;
      pend_bmap_q <= '0;
      pending_q   <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      ra_q        <= 1'b0;
      rv_q        <= 1'b0;
      cc_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bmap_q      <= bmap_d;
      pend_bmap_q <= pend_bmap_d;
      pending_q   <= pending_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      ra_q        <= bus.readoutActive;
      rv_q        <= bus.readoutValid;
      if (bus.FAstrobe) cc_q <= cc_q + 8'd1;
    end
  end

  assign bus.fmpsReadoutAddress = addr_q;
  assign bus.m_tdata            = tdata_q;
  assign bus.m_tvalid           = (state_q == S_EMIT);
  assign bus.m_tlast            = (state_q == S_EMIT) && tlast_q;
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.scanDone           = (state_q == S_DONE);
  assign bus.cycleCounter       = cc_q;

`ifdef FMPS_READOUT_CHECK_EN
  logic [7:0]  cc_snap_q, pend_cc_q;
  logic        err_strobe_q;
  logic [2:0]  err_code_q;
  logic [15:0] err_count_q;
  logic [2:0]  code;
  logic        check_fire;

  always_comb begin
    code = 3'd0;
    if (bus.fmpsReadout[31] || bus.fmpsReadout[30])             code = 3'd1;
    else if (bus.fmpsReadout[29])                                code = 3'd2;
    else if (bus.fmpsReadout[24 +: INDEX_WIDTH] != addr_q)       code = 3'd3;
    else if (bus.fmpsReadout[23:8] != DATA_MAGIC)                code = 3'd4;
    else if (bus.fmpsReadout[7:0] != cc_snap_q)                  code = 3'd5;
  end

  assign check_fire = (state_q == S_SAMPLE) && present && (code != 3'd0);

  // Snapshot timing mirrors the bitmap: live on a fresh start, shadow copy for a pending one.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      cc_snap_q    <= '0;
      pend_cc_q    <= '0;
      err_strobe_q <= 1'b0;
      err_code_q   <= '0;
      err_count_q  <= '0;
    end else begin
      if (((state_q == S_IDLE) || (state_q == S_DONE && !pending_q)) && trigger)
        cc_snap_q <= cc_q;
      else if (state_q == S_DONE && pending_q)
        cc_snap_q <= pend_cc_q;
      if (state_q != S_IDLE && trigger && !pending_q)
        pend_cc_q <= cc_q;
      err_strobe_q <= check_fire;
      if (check_fire) begin
        err_code_q <= code;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign bus.errorStrobe = err_strobe_q;
  assign bus.errorCode   = err_code_q;
  assign bus.errorCount  = err_count_q;
`else
  assign bus.errorStrobe = 1'b0;
  assign bus.errorCode   = 3'd0;
  assign bus.errorCount  = 16'd0;
`endif
endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Directed bench for fmps_readout_sequencer: RAM model, stream monitor and immediate-assert checks.
module tb_fmps_readout_sequencer;
  localparam int IW = 5;
  localparam int N  = 32;
`ifdef FMPS_READOUT_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic sysClk   = 1'b0;
  logic sysReset = 1'b1;

  fmps_readout_sequencer_if #(.INDEX_WIDTH(IW)) bus ();

  fmps_readout_sequencer #(.INDEX_WIDTH(IW), .DATA_MAGIC(16'hCACA)) dut (
    .sysClk   (sysClk),
    .sysReset (sysReset),
    .bus      (bus)
  );

  always #5 sysClk = ~sysClk;

  logic [31:0] mem [N];
  always @(posedge sysClk) bus.fmpsReadout <= mem[bus.fmpsReadoutAddress];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int idx, input logic [7:0] cc);
    logic [4:0] i5;
    i5 = idx[4:0];
    return {3'b000, i5, 16'hCACA, cc};
  endfunction

  // Monitor state, sampled on the falling edge.
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          cyc       = 0;
  int          done_cnt  = 0;
  int          done_cyc  = 0;
  int          valid_cnt = 0;
  int          est_cnt   = 0;
  logic [2:0]  last_code = 3'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  logic        toggle_en  = 1'b0;
  int          trig_cyc   = 0;

  initial forever begin
    @(posedge sysClk);
    cyc++;
  end

  initial forever begin
    @(posedge sysClk);
    #1;
    if (toggle_en) bus.m_tready = ~bus.m_tready;
  end

  initial forever begin
    @(negedge sysClk);
    if (sysReset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.m_tvalid, 1);
        check("stall_data", bus.m_tdata, prev_data);
        check("stall_last", bus.m_tlast, prev_last);
      end
      if (bus.m_tvalid) valid_cnt++;
      if (bus.m_tvalid && bus.m_tready) begin
        got_data.push_back(bus.m_tdata);
        got_last.push_back(bus.m_tlast);
      end
      if (bus.scanDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.errorStrobe) begin
        est_cnt++;
        last_code = bus.errorCode;
      end
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysClk);
      #1;
    end
  endtask

  task automatic trig();
    bus.readoutValid = 1'b1;
    trig_cyc = cyc;
    step(1);
    bus.readoutValid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < 400) begin
      step(1);
      k++;
    end
    check(tag, 32'(done_cnt >= target), 1);
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    int base;
    int v0;
    int e0;
    logic [15:0] ec0;
    logic [31:0] bad;

    bus.readoutActive = 1'b0;
    bus.readoutValid  = 1'b0;
    bus.FAstrobe      = 1'b0;
    bus.fmpsBitmapAll = '0;
    bus.m_tready      = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = word(i, 8'd5);

    // Reset state
    step(3);
    check("rst_addr", bus.fmpsReadoutAddress, 0);
    check("rst_tdata", bus.m_tdata, 0);
    check("rst_tvalid", bus.m_tvalid, 0);
    check("rst_tlast", bus.m_tlast, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.scanDone, 0);
    check("rst_estb", bus.errorStrobe, 0);
    check("rst_ecode", bus.errorCode, 0);
    check("rst_ecount", bus.errorCount, 0);
    check("rst_cc", bus.cycleCounter, 0);
    sysReset = 1'b0;
    step(1);

    bus.FAstrobe = 1'b1;
    step(5);
    bus.FAstrobe = 1'b0;
    step(1);
    check("cc_after5", bus.cycleCounter, 5);

    // Scan 1: entries 0..7, ready held high
    bus.fmpsBitmapAll = 32'h0000_00FF;
    clear_got();
    base = done_cnt;
    trig();
    check("s1_busy", bus.busy, 1);
    check("s1_settle_nv", bus.m_tvalid, 0);
    step(1);
    check("s1_sample_nv", bus.m_tvalid, 0);
    step(1);
    check("s1_lat_valid", bus.m_tvalid, 1);
    check("s1_lat_data", bus.m_tdata, word(0, 8'd5));
    check("s1_lat_addr", bus.fmpsReadoutAddress, 0);
    wait_done(base + 1, "s1_done_seen");
    check("s1_scan_len", done_cyc - trig_cyc, 105);
    check("s1_nwords", got_data.size(), 8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      check($sformatf("s1_data%0d", i), got_data[i], word(i, 8'd5));
      check($sformatf("s1_last%0d", i), got_last[i], (i == 7) ? 1 : 0);
    end
    check("s1_estb_cnt", est_cnt, 0);
    check("s1_ecount", bus.errorCount, 0);
    step(2);

    // Scan 2: same, with ready toggling every cycle
    clear_got();
    base = done_cnt;
    toggle_en = 1'b1;
    trig();
    wait_done(base + 1, "s2_done_seen");
    toggle_en = 1'b0;
    bus.m_tready = 1'b1;
    check("s2_nwords", got_data.size(), 8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      check($sformatf("s2_data%0d", i), got_data[i], word(i, 8'd5));
      check($sformatf("s2_last%0d", i), got_last[i], (i == 7) ? 1 : 0);
    end
    step(2);

    // Scan 3: bad magic on entry 3
    bad = word(3, 8'd5);
    bad[23:8] = 16'hCACB;
    mem[3] = bad;
    clear_got();
    base = done_cnt;
    e0 = est_cnt;
    trig();
    wait_done(base + 1, "s3_done_seen");
    check("s3_nwords", got_data.size(), 8);
    if (got_data.size() > 3) check("s3_fwd_bad", got_data[3], bad);
    check("s3_estb_cnt", est_cnt - e0, CHK);
    check("s3_ecode", last_code, 4 * CHK);
    check("s3_ecount", bus.errorCount, CHK);
    mem[3] = word(3, 8'd5);
    step(2);

    // Scan 4: empty bitmap
    bus.fmpsBitmapAll = '0;
    base = done_cnt;
    v0 = valid_cnt;
    trig();
    wait_done(base + 1, "s4_done_seen");
    check("s4_no_valid", valid_cnt - v0, 0);
    check("s4_scan_len", done_cyc - trig_cyc, 97);
    step(2);

    // Scan 5: one pending trigger accepted, a third dropped
    bus.fmpsBitmapAll = 32'h0000_0001;
    clear_got();
    base = done_cnt;
    trig();
    step(10);
    trig();
    step(10);
    bus.readoutActive = 1'b1;
    step(2);
    bus.readoutActive = 1'b0;
    step(1);
    wait_done(base + 2, "s5_done_seen");
    step(150);
    check("s5_done_cnt", done_cnt - base, 2);
    check("s5_nwords", got_data.size(), 2);
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      check($sformatf("s5_data%0d", i), got_data[i], word(0, 8'd5));
      check($sformatf("s5_last%0d", i), got_last[i], 1);
    end

    // Scan 6: FA strobe coincident with trigger; first and last index present
    bus.fmpsBitmapAll = 32'h8000_0001;
    clear_got();
    base = done_cnt;
    e0 = est_cnt;
    ec0 = bus.errorCount;
    bus.FAstrobe = 1'b1;
    bus.readoutValid = 1'b1;
    trig_cyc = cyc;
    step(1);
    bus.FAstrobe = 1'b0;
    bus.readoutValid = 1'b0;
    wait_done(base + 1, "s6_done_seen");
    check("s6_cc", bus.cycleCounter, 6);
    check("s6_nwords", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("s6_data0", got_data[0], word(0, 8'd5));
      check("s6_last0", got_last[0], 0);
      check("s6_data1", got_data[1], word(31, 8'd5));
      check("s6_last1", got_last[1], 1);
    end
    check("s6_estb_cnt", est_cnt - e0, 0);
    check("s6_ecount", bus.errorCount, ec0);
    step(2);

    // Reset while stalled in EMIT, then a fresh scan
    bus.fmpsBitmapAll = 32'h0000_0001;
    bus.m_tready = 1'b0;
    trig();
    step(2);
    check("r_in_emit", bus.m_tvalid, 1);
    base = done_cnt;
    sysReset = 1'b1;
    #1;
    check("r_tvalid", bus.m_tvalid, 0);
    check("r_busy", bus.busy, 0);
    check("r_tdata", bus.m_tdata, 0);
    check("r_tlast", bus.m_tlast, 0);
    check("r_addr", bus.fmpsReadoutAddress, 0);
    check("r_ecount", bus.errorCount, 0);
    check("r_cc", bus.cycleCounter, 0);
    step(2);
    sysReset = 1'b0;
    bus.m_tready = 1'b1;
    step(1);
    check("r_no_done", done_cnt - base, 0);
    bus.FAstrobe = 1'b1;
    step(5);
    bus.FAstrobe = 1'b0;
    bus.fmpsBitmapAll = 32'h0000_0005;
    clear_got();
    base = done_cnt;
    trig();
    step(2);
    check("r2_valid", bus.m_tvalid, 1);
    check("r2_addr", bus.fmpsReadoutAddress, 0);
    check("r2_data", bus.m_tdata, word(0, 8'd5));
    wait_done(base + 1, "r2_done_seen");
    check("r2_nwords", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("r2_data0", got_data[0], word(0, 8'd5));
      check("r2_last0", got_last[0], 0);
      check("r2_data1", got_data[1], word(2, 8'd5));
      check("r2_last1", got_last[1], 1);
    end
    check("r2_ecount", bus.errorCount, 0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
